// File: rtl/nibble_prog_mem.sv
// nibble_prog_mem: 16 x 8-bit program store for the Nibble 4-bit CPU.
// A host loads the image over a byte-wide valid/ready port. The CPU fetches
// through a combinational read addressed by its 4-bit PC.
// An IDLE/LOAD/RUN state machine sequences the load and drives cpu_run, which
// holds the CPU core in reset until a complete image is present.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   load_start    - pulse; restarts a load from any state (highest priority)
//   load_valid    - host byte valid
//   load_data     - host byte
//   load_last     - qualifies the current byte as the final one
//   load_ready    - block accepts a byte this cycle
//   pc            - CPU fetch address
//   instr         - instruction byte (FILL_BYTE outside RUN)
//   cpu_run       - high only in RUN
//   wr_ptr        - next write address
//   load_len      - bytes accepted in the current or last load (0..16)
//   state         - 00 IDLE, 01 LOAD, 10 RUN
module nibble_prog_mem #(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [3:0] pc,
  output logic [7:0] instr,
  output logic       cpu_run,
  output logic [3:0] wr_ptr,
  output logic [4:0] load_len,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10
  } state_e;

  state_e     state_q;
  logic [7:0] mem_q [16];
  logic [3:0] wr_ptr_q;
  logic [4:0] load_len_q;
  logic       cpu_run_q;
  logic       accept;

  // load_start wins over an in-flight byte, so ready drops while it is high.
  assign load_ready = (state_q == StLoad) && !load_start;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= 4'd0;
      load_len_q <= 5'd0;
      cpu_run_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= FILL_BYTE;
      end
    end else if (load_start) begin
      state_q    <= StLoad;
      wr_ptr_q   <= 4'd0;
      load_len_q <= 5'd0;
      cpu_run_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= FILL_BYTE;
      end
    end else if (accept) begin
      mem_q[wr_ptr_q] <= load_data;
      wr_ptr_q        <= wr_ptr_q + 4'd1;
      load_len_q      <= load_len_q + 5'd1;
      // The 16th byte ends the load even without load_last, so the image
      // can never be overwritten by a wrapped pointer.
      if (load_last || (load_len_q == 5'd15)) begin
        state_q   <= StRun;
        cpu_run_q <= 1'b1;
      end
    end
  end

  assign instr    = cpu_run_q ? mem_q[pc] : FILL_BYTE;
  assign cpu_run  = cpu_run_q;
  assign wr_ptr   = wr_ptr_q;
  assign load_len = load_len_q;
  assign state    = state_q;

endmodule

// File: tb/tb_nibble_prog_mem.sv
// Self-checking bench for nibble_prog_mem. Stimulus pushes expected output
// values into a scoreboard queue; a monitor pops and compares them on the
// falling edge of the same cycle.
module tb_nibble_prog_mem;

  localparam logic [7:0] FILL = 8'hE7;

  localparam int SelReady = 0;
  localparam int SelInstr = 1;
  localparam int SelRun   = 2;
  localparam int SelWrPtr = 3;
  localparam int SelLen   = 4;
  localparam int SelState = 5;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       cpu_run;
  logic [3:0] wr_ptr;
  logic [4:0] load_len;
  logic [1:0] state;

  nibble_prog_mem #(
    .FILL_BYTE(FILL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .pc        (pc),
    .instr     (instr),
    .cpu_run   (cpu_run),
    .wr_ptr    (wr_ptr),
    .load_len  (load_len),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push_exp(input string name, input int sel, input int exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every pending expectation against the settled outputs.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          SelReady: act = int'(load_ready);
          SelInstr: act = int'(instr);
          SelRun:   act = int'(cpu_run);
          SelWrPtr: act = int'(wr_ptr);
          SelLen:   act = int'(load_len);
          default:  act = int'(state);
        endcase
        n_checks++;
        if (act != e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    pc         = 4'd0;
    #1;
    push_exp("rst_state", SelState, 0);
    push_exp("rst_wr_ptr", SelWrPtr, 0);
    push_exp("rst_len", SelLen, 0);
    push_exp("rst_run", SelRun, 0);
    push_exp("rst_ready", SelReady, 0);
    push_exp("rst_instr", SelInstr, FILL);
    @(negedge clk);
    #1;
    step();
    rst_n = 1'b1;

    // Idle ignores load_valid.
    load_valid = 1'b1;
    load_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      push_exp("idle_ready", SelReady, 0);
      step();
    end
    load_valid = 1'b0;
    push_exp("idle_len", SelLen, 0);
    push_exp("idle_state", SelState, 0);

    // Short load: 11, 22, 33(last).
    step();
    load_start = 1'b1;
    push_exp("start_ready", SelReady, 0);
    step();
    load_start = 1'b0;
    begin
      logic [7:0] short_bytes [3];
      short_bytes[0] = 8'h11;
      short_bytes[1] = 8'h22;
      short_bytes[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
        load_valid = 1'b1;
        load_data  = short_bytes[i];
        load_last  = (i == 2);
        push_exp("short_ready", SelReady, 1);
        push_exp("short_wr_ptr", SelWrPtr, i);
        push_exp("short_state", SelState, 1);
        push_exp("short_run_low", SelRun, 0);
        step();
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    push_exp("short_state_run", SelState, 2);
    push_exp("short_len", SelLen, 3);
    push_exp("short_run", SelRun, 1);
    push_exp("short_ready_run", SelReady, 0);
    begin
      int short_exp [4];
      short_exp[0] = 8'h11;
      short_exp[1] = 8'h22;
      short_exp[2] = 8'h33;
      short_exp[3] = FILL;
      for (int i = 0; i < 4; i++) begin
        pc = 4'(i);
        #1;
        push_exp("short_instr", SelInstr, short_exp[i]);
        step();
      end
    end

    // Full load of 00..0F without load_last.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i);
      push_exp("full_wr_ptr", SelWrPtr, i);
      push_exp("full_state", SelState, 1);
      step();
    end
    load_data = 8'h99;  // 17th byte must not be accepted
    pc        = 4'd15;
    #1;
    push_exp("full_ready17", SelReady, 0);
    push_exp("full_state_run", SelState, 2);
    push_exp("full_wr_ptr_wrap", SelWrPtr, 0);
    push_exp("full_len", SelLen, 16);
    push_exp("full_instr15", SelInstr, 8'h0F);
    step();
    load_valid = 1'b0;
    pc         = 4'd0;
    #1;
    push_exp("full_len_hold", SelLen, 16);
    push_exp("full_instr0", SelInstr, 8'h00);
    step();

    // Stalled handshake.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_data  = 8'hC3;
    load_valid = 1'b1;
    push_exp("stall_wr0", SelWrPtr, 0);
    step();
    load_valid = 1'b0;
    load_data  = 8'h5A;
    push_exp("stall_wr1", SelWrPtr, 1);
    step();
    load_valid = 1'b1;
    push_exp("stall_wr1b", SelWrPtr, 1);
    step();
    load_valid = 1'b0;
    push_exp("stall_wr2", SelWrPtr, 2);
    push_exp("stall_len2", SelLen, 2);
    push_exp("stall_state", SelState, 1);

    // Advance to wr_ptr 5, then load_start collides with a valid byte.
    load_valid = 1'b1;
    load_data  = 8'h3C;
    repeat (3) step();
    load_start = 1'b1;
    load_data  = 8'h55;
    push_exp("prio_wr5", SelWrPtr, 5);
    push_exp("prio_ready", SelReady, 0);
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    push_exp("prio_wr0", SelWrPtr, 0);
    push_exp("prio_len0", SelLen, 0);
    push_exp("prio_state", SelState, 1);
    load_valid = 1'b1;
    load_data  = 8'h77;
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    begin
      int prio_pc  [3];
      int prio_exp [3];
      prio_pc[0] = 0; prio_exp[0] = 8'h77;
      prio_pc[1] = 1; prio_exp[1] = FILL;
      prio_pc[2] = 5; prio_exp[2] = FILL;
      for (int i = 0; i < 3; i++) begin
        pc = 4'(prio_pc[i]);
        #1;
        push_exp("prio_instr", SelInstr, prio_exp[i]);
        step();
      end
    end

    // Reload from RUN, then reset mid-load.
    pc         = 4'd0;
    load_start = 1'b1;
    #1;
    push_exp("reload_run_before", SelRun, 1);
    step();
    load_start = 1'b0;
    push_exp("reload_run", SelRun, 0);
    push_exp("reload_instr", SelInstr, FILL);
    push_exp("reload_state", SelState, 1);
    load_valid = 1'b1;
    load_data  = 8'h01;
    step();
    load_data = 8'h02;
    load_last = 1'b0;
    step();
    load_valid = 1'b0;
    push_exp("reload_len2", SelLen, 2);
    step();
    rst_n = 1'b0;
    #1;
    push_exp("arst_state", SelState, 0);
    push_exp("arst_len", SelLen, 0);
    push_exp("arst_run", SelRun, 0);
    push_exp("arst_wr_ptr", SelWrPtr, 0);
    push_exp("arst_ready", SelReady, 0);
    push_exp("arst_instr", SelInstr, FILL);
    step();
    rst_n = 1'b1;
    step();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_prog_mem.md
# nibble_prog_mem

Upstream program store for the Nibble 4-bit CPU. It holds a 16 x 8-bit program image that an external host loads through a byte-wide valid/ready port. It answers the CPU's 4-bit PC with the addressed instruction byte. A small IDLE/LOAD/RUN state machine sequences loading and drives `cpu_run`, which gates the CPU core's reset so the core only executes a complete image.

## Interface
- `FILL_BYTE`, default 8'h00: value written to every location on reset and on `load_start`; also driven on `instr` outside RUN.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_start` in 1: single-cycle pulse; begins a new load from any state.
- `load_valid` in 1: host presents `load_data`.
- `load_data` in 8: instruction byte to store.
- `load_last` in 1: qualifies the current byte as the final byte of the image.
- `load_ready` out 1: block accepts a byte this cycle.
- `pc` in 4: CPU program counter (fetch address).
- `instr` out 8: instruction byte for the CPU's instruction input.
- `cpu_run` out 1: high only in RUN; ANDed into the CPU core reset.
- `wr_ptr` out 4: next write address.
- `load_len` out 5: bytes accepted in the current or last load, 0..16.
- `state` out 2: 00 IDLE, 01 LOAD, 10 RUN; 11 is never produced.

## Operation
- Storage is 16 registers of 8 bits.
- Write address comes from `wr_ptr`; reads are combinational from `pc`.
- IDLE: `load_ready`=0, `cpu_run`=0, `instr`=`FILL_BYTE`. `load_valid` is ignored.
- `load_start`=1, any state:
  - next state LOAD;
  - all 16 locations set to `FILL_BYTE`;
  - `wr_ptr`=0, `load_len`=0.
  - `load_start` overrides every other input in that cycle.
- LOAD: `load_ready` = ~`load_start`. A byte is accepted on a cycle with `load_valid` & `load_ready`:
  - mem[`wr_ptr`] <= `load_data`;
  - `wr_ptr` increments, wrapping 15 -> 0;
  - `load_len` increments.
- LOAD -> RUN when an accepted byte has `load_last`=1, or when the byte is the 16th (`load_len` 15 -> 16).
  - 16th byte: `wr_ptr` wraps to 0 and `load_len`=16.
  - Bytes are never dropped or overwritten within one load.
- `load_last` without `load_valid` has no effect.
- RUN: `cpu_run`=1, `load_ready`=0, `instr` = mem[`pc`]. RUN is left only by `load_start` (-> LOAD) or reset (-> IDLE).
- A load with zero accepted bytes stays in LOAD indefinitely.
- Locations never written in a load read as `FILL_BYTE`.

## Timing
- Reset (async assert, sync release):
  - state IDLE, memory all `FILL_BYTE`;
  - `wr_ptr`=0, `load_len`=0;
  - `cpu_run`=0, `load_ready`=0, `instr`=`FILL_BYTE`.
- Reset asserted mid-load: image discarded, IDLE, no partial RUN.
- Write latency: a byte accepted at edge N is readable via `instr` after edge N (same-cycle combinational read once stored).
- `instr` follows `pc` with zero cycles of latency in RUN. The CPU's 2-cycle fetch/execute needs no wait states.
- `cpu_run` rises on the edge that accepts the final byte. The CPU leaves reset the same edge and fetches PC 0 next cycle.
- `load_start` while in RUN: `cpu_run` falls on that edge and `instr` shows `FILL_BYTE` from that edge.
- `load_ready` is combinational from state and `load_start` only; it never depends on `load_valid`.
- Host may hold `load_valid` across stalls; data must stay stable until accepted.

## Test plan
- Reset then idle: `rst_n`=0 -> all outputs at reset values; `load_valid`=1 with data 8'hAA for 3 cycles -> `load_ready`=0, `load_len`=0, state IDLE.
- Short load: `load_start`, then bytes 8'h11, 8'h22, 8'h33 (last) back-to-back -> RUN after 3rd edge, `load_len`=3, `cpu_run`=1; `pc`=0,1,2,3 -> `instr`=11,22,33,`FILL_BYTE`.
- Full load without `load_last`: 16 bytes 8'h00..8'h0F -> RUN on 16th edge, `wr_ptr`=0, `load_len`=16; `pc`=15 -> 8'h0F. A 17th `load_valid` is not accepted.
- Stalled handshake: `load_valid` toggling 1,0,1,0 with data held -> only valid cycles are written; `wr_ptr` advances by 2.
- Priority: `load_start`=1 together with `load_valid`=1 (8'h55) while in LOAD at `wr_ptr`=5 -> `load_ready`=0, byte not written, `wr_ptr`=0, memory refilled with `FILL_BYTE`.
- Reload and reset: in RUN, pulse `load_start` -> `cpu_run`=0 the next cycle, `instr`=`FILL_BYTE`; assert `rst_n`=0 after 2 accepted bytes -> immediate IDLE, `load_len`=0, `cpu_run`=0.
